// File: rtl/guided_play_pkg.sv
`default_nettype none
// ============================================================================
// Module      : guided_play_pkg
// Description : Shared FSM state type and width helper for guided-play logic.
// Revision    : 1.0 - initial release
// ============================================================================
package guided_play_pkg;

   typedef enum logic [0:0] {
      LISTEN = 1'b0,
      JUDGE  = 1'b1
   } gp_state_t;

   // Index width for n items, never narrower than one bit.
   function automatic int gp_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/guided_play_sequencer_key_edge_priority.sv
`default_nettype none
// ============================================================================
// Module      : key_edge_priority
// Description : Rising-edge detect across keys plus lowest-index encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge_priority
   import guided_play_pkg::*;
#(
   parameter int NUM_KEYS = 8,
   localparam int KW      = gp_width(NUM_KEYS)
) (
   input  logic [NUM_KEYS-1:0] keys_i,
   input  logic [NUM_KEYS-1:0] keys_prev_i,
   output logic                any_edge_o,
   output logic [KW-1:0]       idx_o
);

   logic [NUM_KEYS-1:0] edges;

   assign edges      = keys_i & ~keys_prev_i;
   assign any_edge_o = |edges;

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (edges[i]) begin
            idx_o = KW'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/guided_play_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : guided_play_sequencer
// Description : Judges one key per new press against the song ROM note.
// Revision    : 1.0 - initial release
// ============================================================================
module guided_play_sequencer
   import guided_play_pkg::*;
#(
   parameter int NUM_KEYS       = 8,
   parameter int NOTES_PER_SONG = 9,
   parameter int NUM_SONGS      = 4,
   parameter int MISTAKE_W      = 8,
   localparam int KW            = gp_width(NUM_KEYS),
   localparam int CW            = gp_width(NOTES_PER_SONG),
   localparam int SW            = gp_width(NUM_SONGS)
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [NUM_KEYS-1:0]  keys_in,
   input  logic                 trigger,
   input  logic                 strict_in,
   input  logic                 load_in,
   input  logic [SW-1:0]        song_sel_in,
   input  logic [KW-1:0]        expected_key_in,
   output logic [CW-1:0]        counter,
   output logic [SW-1:0]        song_address,
   output logic [KW-1:0]        key_played,
   output logic                 correct_pulse,
   output logic                 wrong_pulse,
   output logic                 song_done_pulse,
   output logic [MISTAKE_W-1:0] mistakes,
   output logic [MISTAKE_W-1:0] last_mistakes
);

   localparam logic [CW-1:0] LAST_NOTE = CW'(NOTES_PER_SONG - 1);
   localparam logic [SW-1:0] LAST_SONG = SW'(NUM_SONGS - 1);

   gp_state_t             state_q, state_d;
   logic [NUM_KEYS-1:0]   keys_prev_q, keys_prev_d;
   logic [CW-1:0]         counter_q, counter_d;
   logic [SW-1:0]         song_q, song_d;
   logic [KW-1:0]         key_q, key_d;
   logic                  correct_q, correct_d;
   logic                  wrong_q, wrong_d;
   logic                  done_q, done_d;
   logic [MISTAKE_W-1:0]  mist_q, mist_d;
   logic [MISTAKE_W-1:0]  last_q, last_d;

   logic                  any_edge;
   logic [KW-1:0]         edge_idx;
   logic                  advance;

   key_edge_priority #(
      .NUM_KEYS (NUM_KEYS)
   ) u_key_edge_priority (
      .keys_i      (keys_in),
      .keys_prev_i (keys_prev_q),
      .any_edge_o  (any_edge),
      .idx_o       (edge_idx)
   );

   always_comb begin
      state_d     = state_q;
      keys_prev_d = keys_prev_q;
      counter_d   = counter_q;
      song_d      = song_q;
      key_d       = key_q;
      mist_d      = mist_q;
      last_d      = last_q;
      correct_d   = 1'b0;
      wrong_d     = 1'b0;
      done_d      = 1'b0;
      advance     = 1'b0;

      if (load_in) begin
         state_d     = LISTEN;
         keys_prev_d = keys_in;
         counter_d   = '0;
         song_d      = (int'(song_sel_in) >= NUM_SONGS) ? '0 : song_sel_in;
         mist_d      = '0;
      end else begin
         case (state_q)
            LISTEN: begin
               if (trigger) begin
                  keys_prev_d = keys_in;
                  if (any_edge) begin
                     key_d   = edge_idx;
                     state_d = JUDGE;
                  end
               end
            end
            JUDGE: begin
               state_d = LISTEN;
               if (key_q == expected_key_in) begin
                  correct_d = 1'b1;
                  advance   = 1'b1;
               end else begin
                  wrong_d = 1'b1;
                  mist_d  = (&mist_q) ? mist_q : mist_q + 1'b1;
                  advance = ~strict_in;
               end
            end
            default: state_d = LISTEN;
         endcase

         if (advance) begin
            if (counter_q == LAST_NOTE) begin
               // Snapshot includes a mistake made on this final note.
               counter_d = '0;
               done_d    = 1'b1;
               song_d    = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
               last_d    = mist_d;
               mist_d    = '0;
            end else begin
               counter_d = counter_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= LISTEN;
         keys_prev_q <= '0;
         counter_q   <= '0;
         song_q      <= '0;
         key_q       <= '0;
         correct_q   <= 1'b0;
         wrong_q     <= 1'b0;
         done_q      <= 1'b0;
         mist_q      <= '0;
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         keys_prev_q <= keys_prev_d;
         counter_q   <= counter_d;
         song_q      <= song_d;
         key_q       <= key_d;
         correct_q   <= correct_d;
         wrong_q     <= wrong_d;
         done_q      <= done_d;
         mist_q      <= mist_d;
         last_q      <= last_d;
      end
   end

   assign counter         = counter_q;
   assign song_address    = song_q;
   assign key_played      = key_q;
   assign correct_pulse   = correct_q;
   assign wrong_pulse     = wrong_q;
   assign song_done_pulse = done_q;
   assign mistakes        = mist_q;
   assign last_mistakes   = last_q;

endmodule
`default_nettype wire
